// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI transfer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_MAX_CHAR_DEF = 32;

    // Edge-select encoding for the captured tx_neg / rx_neg controls
    localparam logic c_EDGE_POS = 1'b0;
    localparam logic c_EDGE_NEG = 1'b1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_LOAD  = c_ST_LOAD,
        ST_SHIFT = c_ST_SHIFT,
        ST_DONE  = c_ST_DONE
    } state_t;

    function automatic logic edge_sel(input logic sel, input logic pos, input logic neg);
        return (sel == c_EDGE_NEG) ? neg : pos;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_reg
// Description : Bit-indexed tx/rx datapath; bit position derived from the
//               remaining-bit counter owned by the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int MAX_CHAR = c_MAX_CHAR_DEF,
    parameter int CNT_W    = 6
) (
    input  logic                wb_clk,
    input  logic                wb_reset,
    input  logic                load,
    input  logic                tx_fire,
    input  logic                rx_fire,
    input  logic                last_rx,
    input  logic [CNT_W-1:0]    len,
    input  logic [CNT_W-1:0]    cnt,
    input  logic                lsb_first,
    input  logic [MAX_CHAR-1:0] tx_data,
    input  logic                miso,
    output logic                mosi,
    output logic [MAX_CHAR-1:0] rx_data
);

    logic [MAX_CHAR-1:0] r_tx;
    logic [MAX_CHAR-1:0] r_rx;
    logic [MAX_CHAR-1:0] w_rx_nxt;
    logic [CNT_W-1:0]    r_len;
    logic                r_lsb;
    logic [CNT_W-1:0]    w_cnt_eff;
    logic [CNT_W-1:0]    w_first_pos;
    logic [CNT_W-1:0]    w_rx_pos;
    logic [CNT_W-1:0]    w_tx_pos;
    logic                w_first_bit;
    logic                w_tx_bit;

    // Receive acts first, so a same-cycle tx edge drives the bit for the
    // already-decremented count; nothing is driven once no bits remain.
    assign w_cnt_eff   = rx_fire ? (cnt - CNT_W'(1)) : cnt;
    assign w_first_pos = lsb_first ? '0 : (len - CNT_W'(1));
    assign w_rx_pos    = r_lsb ? (r_len - cnt) : (cnt - CNT_W'(1));
    assign w_tx_pos    = r_lsb ? (r_len - w_cnt_eff) : (w_cnt_eff - CNT_W'(1));

    always_comb begin
        w_first_bit = 1'b0;
        w_tx_bit    = 1'b0;
        w_rx_nxt    = r_rx;
        for (int i = 0; i < MAX_CHAR; i++) begin
            if (w_first_pos == CNT_W'(i)) w_first_bit = tx_data[i];
            if (w_tx_pos == CNT_W'(i))    w_tx_bit    = r_tx[i];
            if (rx_fire && (w_rx_pos == CNT_W'(i))) w_rx_nxt[i] = miso;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            r_tx    <= '0;
            r_rx    <= '0;
            r_len   <= '0;
            r_lsb   <= 1'b0;
            mosi    <= 1'b0;
            rx_data <= '0;
        end else if (load) begin
            r_tx  <= tx_data;
            r_rx  <= '0;
            r_len <= len;
            r_lsb <= lsb_first;
            mosi  <= w_first_bit;
        end else begin
            if (rx_fire)                     r_rx    <= w_rx_nxt;
            if (tx_fire && (w_cnt_eff != '0)) mosi    <= w_tx_bit;
            if (last_rx)                     rx_data <= w_rx_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_ctrl
// Description : SPI transfer FSM and bit counter. Define SPI_XFER_LSB_EN to
//               honour the lsb input; otherwise transfers are MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int MAX_CHAR = c_MAX_CHAR_DEF,
    parameter int CNT_W    = 6
) (
    input  logic                wb_clk,
    input  logic                wb_reset,
    input  logic                go,
    input  logic [CNT_W-1:0]    char_len,
    input  logic                tx_neg,
    input  logic                rx_neg,
    input  logic                lsb,
    input  logic [MAX_CHAR-1:0] tx_data,
    input  logic                pos_edge,
    input  logic                neg_edge,
    input  logic                miso,
    output logic                tip,
    output logic                lstclk,
    output logic                mosi,
    output logic [MAX_CHAR-1:0] rx_data,
    output logic                done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tx_sel;
    logic             r_rx_sel;
    logic [CNT_W-1:0] w_len;
    logic             w_lsb_eff;
    logic             w_start;
    logic             w_tx_fire;
    logic             w_rx_fire;
    logic             w_last_rx;

    assign w_len = (char_len == '0) ? CNT_W'(MAX_CHAR) : char_len;

`ifdef SPI_XFER_LSB_EN
    assign w_lsb_eff = lsb;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = lsb;
    assign w_lsb_eff    = 1'b0;
`endif

    always_ff @(posedge wb_clk) begin
        if (wb_reset) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        tip         = 1'b0;
        lstclk      = 1'b0;
        done        = 1'b0;
        w_start     = 1'b0;
        w_tx_fire   = 1'b0;
        w_rx_fire   = 1'b0;
        w_last_rx   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tip         = 1'b1;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                tip       = 1'b1;
                lstclk    = (r_cnt == CNT_W'(1));
                w_tx_fire = edge_sel(r_tx_sel, pos_edge, neg_edge);
                w_rx_fire = edge_sel(r_rx_sel, pos_edge, neg_edge);
                w_last_rx = w_rx_fire && lstclk;
                if (w_last_rx) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            r_cnt    <= '0;
            r_tx_sel <= c_EDGE_POS;
            r_rx_sel <= c_EDGE_POS;
        end else if (w_start) begin
            r_cnt    <= w_len;
            r_tx_sel <= tx_neg ? c_EDGE_NEG : c_EDGE_POS;
            r_rx_sel <= rx_neg ? c_EDGE_NEG : c_EDGE_POS;
        end else if (w_rx_fire) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    spi_shift_reg #(
        .MAX_CHAR (MAX_CHAR),
        .CNT_W    (CNT_W)
    ) u_shift (
        .wb_clk    (wb_clk),
        .wb_reset  (wb_reset),
        .load      (w_start),
        .tx_fire   (w_tx_fire),
        .rx_fire   (w_rx_fire),
        .last_rx   (w_last_rx),
        .len       (w_len),
        .cnt       (r_cnt),
        .lsb_first (w_lsb_eff),
        .tx_data   (tx_data),
        .miso      (miso),
        .mosi      (mosi),
        .rx_data   (rx_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xfer_ctrl
// Description : Self-checking bench for spi_xfer_ctrl against a bit-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_ctrl;

    localparam int MAX_CHAR = 32;
    localparam int CNT_W    = 6;

    logic                wb_clk = 1'b0;
    logic                wb_reset, go, tx_neg, rx_neg, lsb, pos_edge, neg_edge, miso;
    logic [CNT_W-1:0]    char_len;
    logic [MAX_CHAR-1:0] tx_data, rx_data;
    logic                tip, lstclk, mosi, done;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen;

    spi_xfer_ctrl #(.MAX_CHAR(MAX_CHAR), .CNT_W(CNT_W)) dut (
        .wb_clk(wb_clk), .wb_reset(wb_reset), .go(go), .char_len(char_len),
        .tx_neg(tx_neg), .rx_neg(rx_neg), .lsb(lsb), .tx_data(tx_data),
        .pos_edge(pos_edge), .neg_edge(neg_edge), .miso(miso),
        .tip(tip), .lstclk(lstclk), .mosi(mosi), .rx_data(rx_data), .done(done)
    );

    always #5 wb_clk = ~wb_clk;

    // Reference model: phase 0 idle, 1 load, 2 shift, 3 done; m_k = bits received
    int          m_phase = 0;
    int          m_len   = 1;
    int          m_k     = 0;
    bit          m_lsb, m_txn, m_rxn;
    logic [31:0] m_tx, m_acc;
    logic [31:0] m_rx_out = '0;
    logic        m_mosi   = 1'b0;

    function automatic int order(input int k);
        return m_lsb ? k : (m_len - 1 - k);
    endfunction

    task automatic model_step();
        logic rxe, txe;
        rxe = m_rxn ? neg_edge : pos_edge;
        txe = m_txn ? neg_edge : pos_edge;
        if (wb_reset) begin
            m_phase = 0; m_k = 0; m_mosi = 1'b0; m_rx_out = '0; m_acc = '0;
        end else begin
            case (m_phase)
                0: if (go) begin
                    m_len = (char_len == '0) ? MAX_CHAR : int'(char_len);
                    m_tx  = tx_data;
                    m_txn = tx_neg;
                    m_rxn = rx_neg;
`ifdef SPI_XFER_LSB_EN
                    m_lsb = lsb;
`else
                    m_lsb = 1'b0;
`endif
                    m_k = 0; m_acc = '0;
                    m_mosi  = m_tx[order(0)];
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: begin
                    if (rxe) begin
                        m_acc[order(m_k)] = miso;
                        m_k++;
                        if (m_k == m_len) begin
                            m_rx_out = m_acc;
                            m_phase  = 3;
                        end
                    end
                    if (txe && m_k < m_len) m_mosi = m_tx[order(m_k)];
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge wb_clk);
        #1;
        if (done === 1'b1) done_seen++;
        chk("tip", 32'(tip), 32'(m_phase == 1 || m_phase == 2));
        chk("lstclk", 32'(lstclk), 32'(m_phase == 2 && m_k == m_len - 1));
        chk("done", 32'(done), 32'(m_phase == 3));
        chk("rx_data", rx_data, m_rx_out);
        if (m_phase == 1 || m_phase == 2) chk("mosi", 32'(mosi), 32'(m_mosi));
    endtask

    task automatic run_xfer(input logic [CNT_W-1:0] len, input logic [31:0] tx,
                            input bit txn, input bit rxn, input bit lsbv,
                            input bit loopback, input bit simul, input bit noise,
                            input int abort_at, output logic [31:0] seq, output int ndone);
        bit half, fin;
        int gap;
        char_len = len; tx_data = tx; tx_neg = txn; rx_neg = rxn; lsb = lsbv;
        pos_edge = 1'b0; neg_edge = 1'b0; miso = 1'b0; go = 1'b1;
        seq = '0; done_seen = 0;
        tick();
        go = 1'b0; half = 1'b0; gap = 0; fin = 1'b0;
        for (int c = 0; c < 800 && !fin; c++) begin
            pos_edge = 1'b0; neg_edge = 1'b0; go = 1'b0;
            if (gap > 0) gap--;
            else begin
                if (simul && $urandom_range(0, 3) == 0) begin pos_edge = 1'b1; neg_edge = 1'b1; end
                else if (!half) pos_edge = 1'b1;
                else            neg_edge = 1'b1;
                half = ~half;
                gap  = $urandom_range(0, 2);
            end
            miso = loopback ? m_mosi : 1'($urandom);
            if (noise) begin
                go = 1'($urandom); char_len = CNT_W'($urandom); tx_data = $urandom;
            end
            if (m_phase == 2 && (m_rxn ? neg_edge : pos_edge)) seq = {seq[30:0], mosi};
            if (abort_at >= 0 && m_phase == 2 && m_k == abort_at) begin
                wb_reset = 1'b1;
                tick();
                wb_reset = 1'b0;
                fin = 1'b1;
            end else begin
                tick();
                if (done === 1'b1) fin = 1'b1;
            end
        end
        if (!fin) begin
            n_checks++; n_errors++;
            $display("FAIL timeout: done not seen, got 0 expected 1");
        end
        pos_edge = 1'b0; neg_edge = 1'b0; go = 1'b0;
        if (abort_at < 0) begin
            tick();
            tick();
        end
        ndone = done_seen;
    endtask

    typedef struct {
        logic [CNT_W-1:0] len;
        logic [31:0]      tx;
        bit               txn, rxn, lsbv;
        logic [31:0]      exp_rx, exp_seq;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] seq;
    int          nd;

    initial begin
        vecs[0] = '{6'd8,  32'h0000_00A5, 1'b1, 1'b0, 1'b0, 32'h0000_00A5, 32'h0000_00A5};
`ifdef SPI_XFER_LSB_EN
        vecs[1] = '{6'd0,  32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hF77D_B57B};
        vecs[5] = '{6'd12, 32'h0000_0ABC, 1'b1, 1'b0, 1'b1, 32'h0000_0ABC, 32'h0000_03D5};
`else
        vecs[1] = '{6'd0,  32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[5] = '{6'd12, 32'h0000_0ABC, 1'b1, 1'b0, 1'b1, 32'h0000_0ABC, 32'h0000_0ABC};
`endif
        vecs[2] = '{6'd4,  32'h1234_567B, 1'b0, 1'b1, 1'b0, 32'h0000_000B, 32'h0000_000B};
        vecs[3] = '{6'd16, 32'hCAFE_1234, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_1234};
        vecs[4] = '{6'd31, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF};

        wb_reset = 1'b1; go = 1'b0; char_len = '0; tx_neg = 1'b0; rx_neg = 1'b0; lsb = 1'b0;
        tx_data = '0; pos_edge = 1'b0; neg_edge = 1'b0; miso = 1'b0;
        tick();
        tick();
        chk("reset tip", 32'(tip), 32'd0);
        chk("reset mosi", 32'(mosi), 32'd0);
        chk("reset rx_data", rx_data, 32'd0);
        chk("reset done", 32'(done), 32'd0);

        // go together with reset must not start a transfer
        go = 1'b1;
        tick();
        wb_reset = 1'b0; go = 1'b0;
        tick();
        chk("go_in_reset tip", 32'(tip), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i].len, vecs[i].tx, vecs[i].txn, vecs[i].rxn, vecs[i].lsbv,
                     1'b1, 1'b0, 1'(i % 2), -1, seq, nd);
            chk($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_rx);
            chk($sformatf("vec%0d mosi order", i), seq, vecs[i].exp_seq);
            chk($sformatf("vec%0d done pulses", i), 32'(nd), 32'd1);
        end

        // strobes while idle are ignored and leave the next transfer intact
        for (int i = 0; i < 6; i++) begin
            pos_edge = 1'($urandom); neg_edge = 1'($urandom); miso = 1'($urandom);
            tick();
        end
        run_xfer(6'd8, 32'h0000_003C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, seq, nd);
        chk("idle_strobe rx_data", rx_data, 32'h0000_003C);
        chk("idle_strobe done pulses", 32'(nd), 32'd1);

        // reset after 3 of 8 bits, then a clean transfer
        run_xfer(6'd8, 32'h0000_005A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, seq, nd);
        chk("abort tip", 32'(tip), 32'd0);
        chk("abort rx_data", rx_data, 32'd0);
        run_xfer(6'd8, 32'h0000_0096, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, seq, nd);
        chk("post_abort rx_data", rx_data, 32'h0000_0096);

        // single-bit transfer with both strobes in one cycle
        char_len = 6'd1; tx_data = 32'h1; tx_neg = 1'b1; rx_neg = 1'b0; lsb = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("c1 load tip", 32'(tip), 32'd1);
        chk("c1 load mosi", 32'(mosi), 32'd1);
        tick();
        chk("c1 lstclk", 32'(lstclk), 32'd1);
        pos_edge = 1'b1; neg_edge = 1'b1; miso = 1'b1;
        tick();
        pos_edge = 1'b0; neg_edge = 1'b0; miso = 1'b0;
        chk("c1 done", 32'(done), 32'd1);
        chk("c1 rx_data", rx_data, 32'h1);
        tick();
        chk("c1 done width", 32'(done), 32'd0);
        chk("c1 tip after", 32'(tip), 32'd0);

        // randomized transfers against the model
        for (int r = 0; r < 25; r++) begin
            run_xfer(CNT_W'($urandom_range(0, 32)), $urandom, 1'($urandom), 1'($urandom),
                     1'($urandom), 1'b0, 1'b1, 1'($urandom), -1, seq, nd);
            chk($sformatf("rand%0d done pulses", r), 32'(nd), 32'd1);
            chk($sformatf("rand%0d rx_data", r), rx_data, m_rx_out);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
